mul_sched: RTL

- Shares one pipelined `multiplier` instance (in the `clk_div2` domain) among N_REQ requesters, e.g. several async-FIFO front-ends.
- Round-robin issues at most one operand pair per cycle and tags each in-flight op with its requester id.
- Routes each result to a per-requester response FIFO, using credit-based admission so the multiplier pipeline is never back-pressured.
- Provides a flush sequence (drain, reset multiplier, clear FIFOs) for the host CSR reset path.

---
 rtl/mul_sched_pkg.sv | 35 +++
 rtl/mul_sched_fifo.sv | 73 +++++++
 rtl/mul_sched.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mul_sched_pkg.sv
// Shared types and the round-robin pick helper for the multiplier scheduler.
// Tag ids are sized for the largest supported requester count (8).
package mul_sched_pkg;

    localparam int MAX_REQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR, DONE} t_sched_state;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } t_tag;

    // One-hot pick of the first set bit of elig at or after ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] elig,
                                                   input logic [ID_W-1:0]    ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] g;
        logic [ID_W:0]      sum;
        logic               found;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(n)) sum = sum - (ID_W+1)'(n);
            if (k < n && !found && elig[sum[ID_W-1:0]]) begin
                g[sum[ID_W-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mul_sched_fifo.sv
// Synchronous first-word-fall-through response FIFO; clear empties it in one cycle
// and wins over any push or pop in the same cycle.
module rsp_fifo #(
    parameter int DATA_LEN  = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_LEN-1:0]        push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [DATA_LEN-1:0]        rd_data,
    output logic                       empty,
    output logic [$clog2(RSP_DEPTH):0] count
);

    localparam int AW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW  = $clog2(RSP_DEPTH) + 1;
    localparam logic [AW-1:0] LAST = AW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(RSP_DEPTH);

    logic [DATA_LEN-1:0] mem_q [RSP_DEPTH];
    logic [DATA_LEN-1:0] mem_d [RSP_DEPTH];
    logic [AW-1:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                do_pop;

    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rd_data = mem_q[rd_q];
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = (wr_q == LAST) ? '0 : wr_q + 1'b1;
            end
            if (do_pop) rd_d = (rd_q == LAST) ? '0 : rd_q + 1'b1;
            case ({push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !clear && !do_pop && cnt_q == FULL));

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among N_REQ requesters,
// with credit-gated admission into per-requester response FIFOs and a flush sequence.
module mul_sched
    import mul_sched_pkg::*;
#(
    parameter int DATA_LEN  = 32,
    parameter int N_REQ     = 4,
    parameter int LATENCY   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_LEN-1:0] req_a,
    input  logic [N_REQ*DATA_LEN-1:0] req_b,
    output logic [N_REQ-1:0]          rsp_valid,
    input  logic [N_REQ-1:0]          rsp_ready,
    output logic [N_REQ*DATA_LEN-1:0] rsp_data,
    output logic                      mul_issue,
    output logic [DATA_LEN-1:0]       mul_a,
    output logic [DATA_LEN-1:0]       mul_b,
    input  logic [DATA_LEN-1:0]       mul_result,
    output logic                      mul_reset,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic                      busy
);

    localparam int CRD_W = $clog2(RSP_DEPTH) + 1;
    localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(RSP_DEPTH);
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);

    t_sched_state                  state_q, state_d;
    logic [ID_W-1:0]               ptr_q, ptr_d;
    logic [N_REQ-1:0][CRD_W-1:0]   credit_q, credit_d;
    logic                          mul_issue_q, mul_issue_d;
    logic [DATA_LEN-1:0]           mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [ID_W-1:0]               issue_id_q, issue_id_d;
    t_tag [LATENCY-1:0]            tag_q, tag_d;

    logic [N_REQ-1:0]              elig, grant, accept, pop, push, empty;
    logic [MAX_REQ-1:0]            elig_pad, pick;
    logic [ID_W-1:0]               gidx;
    logic                          pipe_busy;
    logic [N_REQ-1:0][CRD_W-1:0]   occ;

    // Grants are suppressed while reset is held and in the cycle a flush is requested.
    always_comb begin
        for (int i = 0; i < N_REQ; i++)
            elig[i] = req_valid[i] && (credit_q[i] != '0);
        if (reset || state_q != RUN || flush_req) elig = '0;
        elig_pad             = '0;
        elig_pad[N_REQ-1:0]  = elig;
        pick                 = rr_pick(elig_pad, ptr_q, N_REQ);
        grant                = pick[N_REQ-1:0];
        gidx                 = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) gidx = ID_W'(i);
    end

    assign req_ready = grant;
    assign accept    = req_valid & grant;
    assign rsp_valid = ~empty;
    assign pop       = rsp_valid & rsp_ready;

    always_comb begin
        pipe_busy = mul_issue_q;
        for (int k = 0; k < LATENCY; k++)
            pipe_busy = pipe_busy | tag_q[k].valid;
    end

    always_comb begin
        mul_issue_d = |accept;
        mul_a_d     = '0;
        mul_b_d     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i]) begin
                mul_a_d = req_a[i*DATA_LEN +: DATA_LEN];
                mul_b_d = req_b[i*DATA_LEN +: DATA_LEN];
            end
        end
        issue_id_d = gidx;

        tag_d[0] = '{valid: mul_issue_q, id: issue_id_q};
        for (int k = 1; k < LATENCY; k++)
            tag_d[k] = tag_q[k-1];

        ptr_d = ptr_q;
        if (|accept) ptr_d = (gidx == LAST_ID) ? '0 : gidx + 1'b1;

        credit_d = credit_q;
        for (int i = 0; i < N_REQ; i++) begin
            case ({accept[i], pop[i]})
                2'b10:   credit_d[i] = credit_q[i] - 1'b1;
                2'b01:   credit_d[i] = credit_q[i] + 1'b1;
                default: credit_d[i] = credit_q[i];
            endcase
        end

        state_d = state_q;
        case (state_q)
            RUN:   if (flush_req) state_d = DRAIN;
            DRAIN: if (!pipe_busy) state_d = CLEAR;
            CLEAR: begin
                state_d  = DONE;
                ptr_d    = '0;
                credit_d = {N_REQ{CRD_FULL}};
            end
            DONE:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            ptr_q       <= '0;
            credit_q    <= {N_REQ{CRD_FULL}};
            mul_issue_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            issue_id_q  <= '0;
            tag_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            credit_q    <= credit_d;
            mul_issue_q <= mul_issue_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            issue_id_q  <= issue_id_d;
            tag_q       <= tag_d;
        end
    end

    assign mul_issue  = mul_issue_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign mul_reset  = (state_q == CLEAR);
    assign flush_done = (state_q == DONE);
    assign busy       = pipe_busy || (|rsp_valid);

    genvar i;
    generate
        for (i = 0; i < N_REQ; i++) begin : g_rsp
            assign push[i] = tag_q[LATENCY-1].valid && (tag_q[LATENCY-1].id == ID_W'(i));

            rsp_fifo #(
                .DATA_LEN  (DATA_LEN),
                .RSP_DEPTH (RSP_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push      (push[i]),
                .push_data (mul_result),
                .pop       (pop[i]),
                .clear     (state_q == CLEAR),
                .rd_data   (rsp_data[i*DATA_LEN +: DATA_LEN]),
                .empty     (empty[i]),
                .count     (occ[i])
            );

            // Stored entries plus free credits can never exceed the FIFO depth.
            credit_bound: assert property (@(posedge clk) disable iff (reset)
                (CRD_W+1)'(occ[i]) + (CRD_W+1)'(credit_q[i]) <= (CRD_W+1)'(RSP_DEPTH));
        end
    endgenerate

endmodule
